// File: rtl/mac_pkg.sv
// mac_pkg: types and defaults shared by the MAC pipeline front end.
//   fp64_t          : raw IEEE-754 binary64 operand container
//   feeder_state_e  : job sequencing states of mac_operand_feeder
//   K_MAX_DEFAULT   : longest dot product a single job may request
//   TIMEOUT_DEFAULT : store-wait watchdog limit in cycles
package mac_pkg;

  typedef logic [63:0] fp64_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_STORE = 2'd2
  } feeder_state_e;

  localparam int K_MAX_DEFAULT   = 16;
  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: sequences one dot-product job into the MAC.
//   A job is K operand pairs plus a seed C. The feeder accepts a descriptor,
//   pairs the A and B streams, issues one registered beat per pair, then waits
//   for the MAC's store_valid before reporting done.
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   job_valid_i/job_ready_o  : job descriptor handshake (job_k_i, job_c_i)
//   a_*/b_*                  : operand streams, accepted together or not at all
//   mac_valid_o, mac_ta_o, mac_tb_o, mac_c_o : MAC operand interface
//   mac_load_valid_i, mac_store_valid_i, mac_error_i : MAC status
//   busy_o, done_o, err_o, issued_o : tile controller status
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int K_MAX   = K_MAX_DEFAULT,
  parameter int CNT_W   = $clog2(K_MAX + 1),
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid_i,
  output logic              job_ready_o,
  input  logic [CNT_W-1:0]  job_k_i,
  input  logic [DATA_W-1:0] job_c_i,
  input  logic              a_valid_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic              mac_valid_o,
  output logic [DATA_W-1:0] mac_ta_o,
  output logic [DATA_W-1:0] mac_tb_o,
  output logic [DATA_W-1:0] mac_c_o,
  input  logic              mac_load_valid_i,
  input  logic              mac_store_valid_i,
  input  logic              mac_error_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  issued_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] K_MAX_C   = CNT_W'(K_MAX);
  localparam logic [WD_W-1:0]  WD_LAST_C = WD_W'(TIMEOUT - 1);

  feeder_state_e     state_reg, state_next;
  logic [CNT_W-1:0]  k_reg, k_next;
  logic [CNT_W-1:0]  issued_reg, issued_next;
  logic [WD_W-1:0]   wd_reg, wd_next;
  logic              mac_valid_reg, mac_valid_next;
  logic [DATA_W-1:0] ta_reg, ta_next;
  logic [DATA_W-1:0] tb_reg, tb_next;
  logic [DATA_W-1:0] c_reg, c_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              pair_fire;
  logic              job_accept;

  // A pair only moves when both streams offer data, so neither stream can
  // be consumed without its partner.
  assign pair_fire  = (state_reg == ISSUE) && a_valid_i && b_valid_i;
  // Holding off acceptance during the done pulse keeps the controller from
  // seeing done and a fresh accept in the same cycle.
  assign job_ready_o = (state_reg == IDLE) && !done_reg;
  assign job_accept  = job_ready_o && job_valid_i;

  assign a_ready_o   = pair_fire;
  assign b_ready_o   = pair_fire;
  assign mac_valid_o = mac_valid_reg;
  assign mac_ta_o    = ta_reg;
  assign mac_tb_o    = tb_reg;
  assign mac_c_o     = c_reg;
  assign busy_o      = (state_reg != IDLE);
  assign done_o      = done_reg;
  assign err_o       = err_reg;
  assign issued_o    = issued_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      issued_reg    <= '0;
      wd_reg        <= '0;
      mac_valid_reg <= 1'b0;
      ta_reg        <= '0;
      tb_reg        <= '0;
      c_reg         <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      k_reg         <= k_next;
      issued_reg    <= issued_next;
      wd_reg        <= wd_next;
      mac_valid_reg <= mac_valid_next;
      ta_reg        <= ta_next;
      tb_reg        <= tb_next;
      c_reg         <= c_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    k_next         = k_reg;
    issued_next    = issued_reg;
    wd_next        = wd_reg;
    mac_valid_next = 1'b0;
    ta_next        = ta_reg;
    tb_next        = tb_reg;
    c_next         = c_reg;
    done_next      = 1'b0;
    err_next       = err_reg;

    // Protocol violations from the MAC side are recorded but never stall
    // the job; the controller decides what to do with a flagged result.
    if (mac_error_i) err_next = 1'b1;
    if (mac_load_valid_i && (state_reg == IDLE)) err_next = 1'b1;
    if (mac_store_valid_i && (state_reg != WAIT_STORE)) err_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (job_accept) begin
          if ((job_k_i == '0) || (job_k_i > K_MAX_C)) begin
            err_next  = 1'b1;
            done_next = 1'b1;
          end else begin
            state_next  = ISSUE;
            k_next      = job_k_i;
            issued_next = '0;
            c_next      = job_c_i;
          end
        end
      end
      ISSUE: begin
        if (pair_fire) begin
          mac_valid_next = 1'b1;
          ta_next        = a_data_i;
          tb_next        = b_data_i;
          issued_next    = issued_reg + CNT_W'(1);
          if (issued_next == k_reg) begin
            state_next = WAIT_STORE;
            wd_next    = '0;
          end
        end
      end
      WAIT_STORE: begin
        // store_valid is checked first so a result arriving on the last
        // watchdog cycle still counts as a success.
        if (mac_store_valid_i) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (wd_reg == WD_LAST_C) begin
          err_next   = 1'b1;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          wd_next = wd_reg + WD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
module tb_mac_operand_feeder;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              job_valid;
  logic              job_ready_o;
  logic [CNT_W-1:0]  job_k;
  logic [DATA_W-1:0] job_c;
  logic              a_valid, b_valid;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready_o, b_ready_o;
  logic              mac_valid_o;
  logic [DATA_W-1:0] mac_ta_o, mac_tb_o, mac_c_o;
  logic              mac_load_valid, mac_store_valid, mac_error;
  logic              busy_o, done_o, err_o;
  logic [CNT_W-1:0]  issued_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    int          cyc;
  } beat_t;
  beat_t q[$];

  typedef struct {
    logic [4:0]  k;
    logic [63:0] c;
    logic [3:0]  amask;
    logic [3:0]  bmask;
    int          store_delay;
    logic        exp_err;
  } vec_t;
  vec_t vecs[7];

  mac_operand_feeder dut (
    .clk(clk), .rst(rst),
    .job_valid_i(job_valid), .job_ready_o(job_ready_o),
    .job_k_i(job_k), .job_c_i(job_c),
    .a_valid_i(a_valid), .a_data_i(a_data), .a_ready_o(a_ready_o),
    .b_valid_i(b_valid), .b_data_i(b_data), .b_ready_o(b_ready_o),
    .mac_valid_o(mac_valid_o), .mac_ta_o(mac_ta_o), .mac_tb_o(mac_tb_o),
    .mac_c_o(mac_c_o),
    .mac_load_valid_i(mac_load_valid), .mac_store_valid_i(mac_store_valid),
    .mac_error_i(mac_error),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .issued_o(issued_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every beat must match the oldest pushed pair and arrive
  // exactly one cycle after its handshake.
  always @(negedge clk) begin
    beat_t e;
    if (mac_valid_o === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected: got ta=%h tb=%h expected no beat", mac_ta_o, mac_tb_o);
      end else begin
        e = q.pop_front();
        chk("beat_ta", mac_ta_o, e.a);
        chk("beat_tb", mac_tb_o, e.b);
        chk("beat_cycle", 64'(cyc), 64'(e.cyc + 1));
      end
    end
  end

  task automatic chk_reset_values();
    chk("rst_mac_valid", mac_valid_o, 0);
    chk("rst_ta", mac_ta_o, 0);
    chk("rst_tb", mac_tb_o, 0);
    chk("rst_c", mac_c_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_issued", issued_o, 0);
    chk("rst_busy", busy_o, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    job_valid = 0; a_valid = 0; b_valid = 0;
    mac_load_valid = 0; mac_store_valid = 0; mac_error = 0;
    @(negedge clk);
    chk_reset_values();
    rst = 1'b0;
    q.delete();
  endtask

  // Called right after a negedge; returns at the negedge after the accept edge.
  task automatic accept_job(input logic [4:0] k, input logic [63:0] c);
    job_valid = 1'b1; job_k = k; job_c = c;
    #1 chk("job_ready_accept", job_ready_o, 1);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  // Offers pairs until n have fired; returns at the negedge after the last fire.
  task automatic issue_pairs(input int n, input logic [3:0] amask, input logic [3:0] bmask,
                             input int store_at, input int merr_at);
    int fired = 0;
    int i = 0;
    while (fired < n && i < 200) begin
      a_valid = amask[i % 4];
      b_valid = bmask[i % 4];
      a_data = {$urandom, $urandom};
      b_data = {$urandom, $urandom};
      mac_store_valid = (i == store_at);
      mac_error = (i == merr_at);
      #1;
      chk("a_ready", a_ready_o, a_valid && b_valid);
      chk("b_ready", b_ready_o, a_valid && b_valid);
      if (a_valid && b_valid) begin
        q.push_back('{a_data, b_data, cyc});
        fired++;
      end
      @(negedge clk);
      i++;
    end
    a_valid = 0; b_valid = 0; mac_store_valid = 0; mac_error = 0;
    if (fired < n) begin
      checks++;
      errors++;
      $display("FAIL issue_budget: got %0d pairs expected %0d", fired, n);
    end
  endtask

  // Entered at the first negedge of WAIT_STORE.
  task automatic finish_job(input int delay, input logic exp_err, input logic [63:0] c);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      chk("done_early", done_o, 0);
    end
    mac_store_valid = 1'b1;
    @(negedge clk);
    mac_store_valid = 1'b0;
    chk("done_pulse", done_o, 1);
    chk("done_err", err_o, exp_err);
    chk("done_busy", busy_o, 0);
    chk("done_ready_blocked", job_ready_o, 0);
    chk("c_held", mac_c_o, c);
    @(negedge clk);
    chk("done_single", done_o, 0);
    chk("ready_after_done", job_ready_o, 1);
    chk("queue_drained", 64'(q.size()), 0);
  endtask

  initial begin
    int first;
    vecs[0] = '{5'd3,  64'h4003800000000000, 4'b1111, 4'b1111, 0, 1'b0};
    vecs[1] = '{5'd4,  64'h3ff0000000000000, 4'b1111, 4'b0101, 2, 1'b0};
    vecs[2] = '{5'd0,  64'hdeadbeef00000000, 4'b1111, 4'b1111, 0, 1'b1};
    vecs[3] = '{5'd17, 64'h4000000000000000, 4'b1111, 4'b1111, 0, 1'b1};
    vecs[4] = '{5'd16, 64'hc008000000000000, 4'b1011, 4'b1110, 5, 1'b0};
    vecs[5] = '{5'd1,  64'h0000000000000001, 4'b0011, 4'b0110, 1, 1'b0};
    vecs[6] = '{5'd31, 64'h7ff0000000000000, 4'b1111, 4'b1111, 0, 1'b1};
    job_k = '0; job_c = '0; a_data = '0; b_data = '0;

    do_reset();
    chk("rst_job_ready", job_ready_o, 1);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      accept_job(vecs[v].k, vecs[v].c);
      if (vecs[v].exp_err) begin
        chk("bad_k_done", done_o, 1);
        chk("bad_k_err", err_o, 1);
        chk("bad_k_busy", busy_o, 0);
        chk("bad_k_c_untouched", mac_c_o, 0);
        @(negedge clk);
        chk("bad_k_done_single", done_o, 0);
        chk("bad_k_ready", job_ready_o, 1);
        chk("bad_k_err_sticky", err_o, 1);
      end else begin
        chk("accept_busy", busy_o, 1);
        chk("accept_issued", issued_o, 0);
        chk("accept_c", mac_c_o, vecs[v].c);
        issue_pairs(int'(vecs[v].k), vecs[v].amask, vecs[v].bmask, -1, -1);
        chk("issued_count", issued_o, vecs[v].k);
        chk("wait_busy", busy_o, 1);
        chk("wait_a_ready", a_ready_o, 0);
        finish_job(vecs[v].store_delay, 1'b0, vecs[v].c);
      end
      $display("job %0d k=%0d c=%h err=%0d completed", v, vecs[v].k, vecs[v].c, err_o);
    end

    // Watchdog: no store_valid, done+err 64 cycles after entering WAIT_STORE.
    do_reset();
    accept_job(5'd2, 64'h1);
    issue_pairs(2, 4'b1111, 4'b1111, -1, -1);
    first = -1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (done_o && first < 0) first = i;
    end
    chk("timeout_cycle", 64'(first), 64);
    chk("timeout_err", err_o, 1);
    chk("timeout_idle", busy_o, 0);
    $display("job watchdog done after %0d cycles", first);

    // store_valid on the final watchdog cycle is a success.
    do_reset();
    accept_job(5'd2, 64'h2);
    issue_pairs(2, 4'b1111, 4'b1111, -1, -1);
    repeat (63) @(negedge clk);
    chk("edge_no_done_yet", done_o, 0);
    mac_store_valid = 1'b1;
    @(negedge clk);
    mac_store_valid = 1'b0;
    chk("edge_store_done", done_o, 1);
    chk("edge_store_no_err", err_o, 0);
    $display("job store-at-timeout done err=%0d", err_o);

    // Reset mid-job after 2 of 5 pairs; the pair offered during reset is dropped.
    do_reset();
    accept_job(5'd5, 64'h5);
    issue_pairs(2, 4'b1111, 4'b1111, -1, -1);
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk);
    chk_reset_values();
    a_valid = 0; b_valid = 0; rst = 1'b0;
    chk("midrst_no_pending", 64'(q.size()), 0);
    accept_job(5'd1, 64'h3ff8000000000000);
    issue_pairs(1, 4'b1111, 4'b1111, -1, -1);
    finish_job(0, 1'b0, 64'h3ff8000000000000);
    $display("job after mid-job reset completed");

    // store_valid during ISSUE flags an error, job still completes.
    do_reset();
    accept_job(5'd3, 64'h6);
    issue_pairs(3, 4'b1111, 4'b1101, 1, -1);
    chk("stray_store_err", err_o, 1);
    finish_job(1, 1'b1, 64'h6);
    $display("job with stray store_valid completed err=%0d", err_o);

    // mac_error pulse flags a sticky error, job still completes.
    do_reset();
    accept_job(5'd3, 64'h7);
    issue_pairs(3, 4'b1111, 4'b1101, -1, 2);
    chk("mac_error_err", err_o, 1);
    finish_job(0, 1'b1, 64'h7);
    @(negedge clk);
    chk("err_sticky_idle", err_o, 1);
    $display("job with mac_error completed err=%0d", err_o);

    // load_valid is legal while a job owns C, illegal while idle.
    do_reset();
    accept_job(5'd2, 64'h8);
    mac_load_valid = 1'b1;
    issue_pairs(2, 4'b1111, 4'b1111, -1, -1);
    mac_load_valid = 1'b0;
    chk("load_in_job_ok", err_o, 0);
    finish_job(0, 1'b0, 64'h8);
    mac_load_valid = 1'b1;
    @(negedge clk);
    mac_load_valid = 1'b0;
    chk("load_idle_err", err_o, 1);
    $display("job load_valid ownership checked err=%0d", err_o);

    chk("final_queue_empty", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
